// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// The optional signed-overflow output is selected with SERIAL_ADDER_OVERFLOW_EN.
package serial_adder_pkg;

  // Default operand width in bits.
  localparam int unsigned SERIAL_ADDER_WIDTH_DEF = 8;

  // Controller phases: waiting for operands, adding bits, holding the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter width that indexes bit positions 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// 1-bit full-adder cell built from gates only.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ab_x;
  logic ab_a;
  logic xc_a;

  // Sum is the three-input parity; carry is the majority.
  assign ab_x = a ^ b;
  assign ab_a = a & b;
  assign xc_a = ab_x & ci;
  assign s    = ab_x ^ ci;
  assign co   = ab_a | xc_a;

endmodule

// File: rtl/serial_adder_operand_sreg.sv
// Operand and sum shift registers for the bit-serial adder.
// Operands shift right (LSB out first); sum bits enter at the MSB end.
module serial_adder_operand_sreg
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sum_bit,
  output logic             a_lsb,
  output logic             b_lsb,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;

  // Load fresh operands and clear the sum, or advance all three by one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
    end else if (shift) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      sum_sr <= {sum_bit, sum_sr[WIDTH-1:1]};
    end
  end

  assign a_lsb = a_sr[0];
  assign b_lsb = b_sr[0];
  assign sum   = sum_sr;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts a, b, cin, adds one bit per cycle LSB
// first through a single full-adder cell, and presents sum/cout on a
// valid/ready output. Define SERIAL_ADDER_OVERFLOW_EN to add the ovf output.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             load;
  logic             shift;
  logic             last;
  logic             out_hs;
  logic             a_lsb;
  logic             b_lsb;
  logic             fa_sum;
  logic             fa_carry;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode; handshake readiness depends on state only.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    last       = 1'b0;
    out_hs     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt == CNT_LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) begin
          out_hs     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit counter and carry flop; the carry holds cout once the add completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      carry <= cin;
    end else if (shift) begin
      cnt   <= cnt + CNT_W'(1);
      carry <= fa_carry;
    end
  end

  // Result-valid flag: set on the last bit edge, cleared by the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (last) begin
      out_valid <= 1'b1;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (load) begin
      ovf <= 1'b0;
    end else if (last) begin
      ovf <= carry ^ fa_carry;
    end
  end
`endif

  assign cout = carry;

  serial_adder_fa u_fa (
    .a  (a_lsb),
    .b  (b_lsb),
    .ci (carry),
    .s  (fa_sum),
    .co (fa_carry)
  );

  serial_adder_operand_sreg #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .shift   (shift),
    .a       (a),
    .b       (b),
    .sum_bit (fa_sum),
    .a_lsb   (a_lsb),
    .b_lsb   (b_lsb),
    .sum     (sum)
  );

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against an arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full (WIDTH+1)-bit reference result: bit W is the carry-out.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  // One complete operation; optionally pokes in_valid while busy and stalls out_ready.
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_c,
                       input int hold, input bit poke);
    logic [W:0] full;
    int lat;
    full = ref_add(op_a, op_b, op_c);
    check("idle_in_ready", 64'(in_ready), 64'(1));
    a = op_a; b = op_b; cin = op_c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
    lat = 0;
    while (!out_valid && lat < int'(W) + 4) begin
      if (poke) begin
        check("in_ready_shift", 64'(in_ready), 64'(0));
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      tick();
      in_valid = 1'b0;
      lat++;
    end
    check("latency", 64'(lat), 64'(W));
    check("out_valid", 64'(out_valid), 64'(1));
    check("sum", 64'(sum), 64'(full[W-1:0]));
    check("cout", 64'(cout), 64'(full[W]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("ovf", 64'(ovf),
          64'((op_a[W-1] == op_b[W-1]) && (full[W-1] != op_a[W-1])));
`endif
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        check("in_ready_done", 64'(in_ready), 64'(0));
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      end
      tick();
      in_valid = 1'b0;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_sum", 64'({cout, sum}), 64'(full));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("after_hs_valid", 64'(out_valid), 64'(0));
    check("after_hs_in_ready", 64'(in_ready), 64'(1));
    check("after_hs_busy", 64'(busy), 64'(0));
  endtask

  // in_valid and out_ready held high; results checked in order, accept spacing measured.
  task automatic back_to_back(input int n_ops);
    logic [W:0] exp_q[$];
    logic [W:0] exp_v;
    int n_acc;
    int prev_acc;
    int cyc;
    n_acc = 0;
    prev_acc = -1;
    cyc = 0;
    out_ready = 1'b1;
    while ((n_acc < n_ops || exp_q.size() > 0) && cyc < (n_ops + 2) * (int'(W) + 2) + 20) begin
      if (out_valid) begin
        exp_v = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        check("b2b_result", 64'({cout, sum}), 64'(exp_v));
      end
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      in_valid = (n_acc < n_ops);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(a, b, cin));
        if (prev_acc >= 0) check("b2b_spacing", 64'(cyc - prev_acc), 64'(W + 2));
        prev_acc = cyc;
        n_acc++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'(n_ops));
    check("b2b_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("rst_ovf", 64'(ovf), 64'(0));
`endif
    rst_n = 1'b1;
    tick();

    do_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 1, 1'b0);
    do_op(8'h5A, 8'hA5, 1'b1, 5, 1'b1);

    // Reset mid-operation: after the edge that leaves cnt at 3.
    a = 8'hAB; b = 8'hCD; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick();
      check("midrst_no_stale", 64'(out_valid), 64'(0));
    end
    do_op(8'h12, 8'h34, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom));
    end

    back_to_back(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
